// File: rtl/keyer_pkg.sv
// keyer_pkg: shared types and constants for the iambic keyer.
//   keyer_state_e : FSM state encoding (IDLE, DOT, DASH, GAP)
//   ACC_LIMIT     : unit-timer accumulator threshold (1200 = ms per unit at 1 WPM)
//   WPM_MIN/MAX   : legal speed range; out-of-range speeds are clamped
//   DASH_UNITS    : dash length in units
//   clamp_wpm()   : saturates a raw 6-bit speed setting into WPM_MIN..WPM_MAX
package keyer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOT  = 2'd1,
    DASH = 2'd2,
    GAP  = 2'd3
  } keyer_state_e;

  localparam int ACC_LIMIT  = 1200;
  localparam int WPM_MIN    = 5;
  localparam int WPM_MAX    = 60;
  localparam int DASH_UNITS = 3;

  function automatic logic [5:0] clamp_wpm(input logic [5:0] w);
    if (w < 6'(WPM_MIN)) begin
      return 6'(WPM_MIN);
    end else if (w > 6'(WPM_MAX)) begin
      return 6'(WPM_MAX);
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/keyer_debounce.sv
// keyer_debounce: 2-FF synchroniser followed by a stable-time debouncer.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (output reads released = 1)
//   tick_i  : 1 ms strobe, one clock wide
//   raw_i   : asynchronous raw pin level
//   level_o : debounced level; follows the synchronised level only after it
//             has differed from the current output for DEBOUNCE_MS ticks in a row
module keyer_debounce #(
  parameter int DEBOUNCE_MS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the input agrees with the accepted level restarts the
  // count, so only an uninterrupted run of ticks can flip the output.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/iambic_keyer.sv
// iambic_keyer: iambic A/B CW keyer with paddle debouncing and sidetone.
//   IF_clk        : clock
//   extreset      : asynchronous active-low reset
//   enable        : low forces the keyer idle on the next cycle
//   mode_b        : 1 = iambic B (element memories), 0 = iambic A
//   reverse       : swap dot and dash paddles
//   wpm           : speed in words per minute, clamped to 5..60
//   paddle_dot_n  : raw dot paddle, active low
//   paddle_dash_n : raw dash paddle, active low
//   cwkey_o       : key down when high
//   sidetone      : square wave while keyed, low otherwise
//   busy          : FSM is not idle
module iambic_keyer
  import keyer_pkg::*;
#(
  parameter int CLK_FREQ    = 73728000,
  parameter int DEBOUNCE_MS = 4,
  parameter int SIDETONE_HZ = 600
) (
  input  logic       IF_clk,
  input  logic       extreset,
  input  logic       enable,
  input  logic       mode_b,
  input  logic       reverse,
  input  logic [5:0] wpm,
  input  logic       paddle_dot_n,
  input  logic       paddle_dash_n,
  output logic       cwkey_o,
  output logic       sidetone,
  output logic       busy
);

  localparam int MS_DIV   = CLK_FREQ / 1000;
  localparam int HALF_PER = CLK_FREQ / (2 * SIDETONE_HZ);
  localparam int MSW      = $clog2(MS_DIV + 1);
  localparam int TW       = $clog2(HALF_PER + 1);

  logic [MSW-1:0] ms_cnt_q, el_cnt_q, el_cnt_d;
  logic           ms_tick, el_tick, unit_tick;
  logic           dot_lvl, dash_lvl, dot_p, dash_p, dot_req, dash_req;
  keyer_state_e   state_q, state_d;
  logic           last_dash_q, last_dash_d;
  logic           dot_mem_q, dot_mem_d, dash_mem_q, dash_mem_d;
  logic [10:0]    acc_q, acc_d, acc_wrap;
  logic [11:0]    acc_sum;
  logic [1:0]     units_q, units_d;
  logic           go_elem, go_dash, key_d, cwkey_q;
  logic [TW-1:0]  tone_cnt_q, tone_cnt_d;
  logic           tone_q, tone_d;
  logic [5:0]     wpm_c;

  // Free-running 1 ms strobe for the debouncers.
  assign ms_tick = (ms_cnt_q == MSW'(MS_DIV - 1));

  always_ff @(posedge IF_clk or negedge extreset) begin
    if (!extreset) begin
      ms_cnt_q <= '0;
    end else begin
      ms_cnt_q <= ms_tick ? '0 : ms_cnt_q + MSW'(1);
    end
  end

  keyer_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_dot (
    .clk_i(IF_clk), .rst_ni(extreset), .tick_i(ms_tick),
    .raw_i(paddle_dot_n), .level_o(dot_lvl)
  );

  keyer_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_dash (
    .clk_i(IF_clk), .rst_ni(extreset), .tick_i(ms_tick),
    .raw_i(paddle_dash_n), .level_o(dash_lvl)
  );

  assign dot_p    = reverse ? ~dash_lvl : ~dot_lvl;
  assign dash_p   = reverse ? ~dot_lvl  : ~dash_lvl;
  assign dot_req  = dot_p  | dot_mem_q;
  assign dash_req = dash_p | dash_mem_q;

  // Unit timer: a separate ms prescaler that is re-phased at element start,
  // so the first unit of every element is full length.
  assign wpm_c     = clamp_wpm(wpm);
  assign el_tick   = (el_cnt_q == MSW'(MS_DIV - 1));
  assign acc_sum   = {1'b0, acc_q} + {6'd0, wpm_c};
  assign acc_wrap  = acc_sum[10:0] - 11'(ACC_LIMIT);
  assign unit_tick = el_tick && (acc_sum >= 12'(ACC_LIMIT));

  always_comb begin
    state_d     = state_q;
    last_dash_d = last_dash_q;
    dot_mem_d   = dot_mem_q;
    dash_mem_d  = dash_mem_q;
    acc_d       = acc_q;
    units_d     = units_q;
    el_cnt_d    = el_tick ? '0 : el_cnt_q + MSW'(1);
    go_elem     = 1'b0;
    go_dash     = 1'b0;

    if (el_tick) acc_d = unit_tick ? acc_wrap : acc_sum[10:0];
    if (unit_tick) units_d = units_q + 2'd1;

    case (state_q)
      IDLE: begin
        // Dot wins a simultaneous press.
        go_elem = dot_p | dash_p;
        go_dash = ~dot_p;
      end
      DOT: begin
        if (mode_b && dash_p) dash_mem_d = 1'b1;
        if (unit_tick) begin
          state_d     = GAP;
          last_dash_d = 1'b0;
        end
      end
      DASH: begin
        if (mode_b && dot_p) dot_mem_d = 1'b1;
        if (unit_tick && units_q == 2'(DASH_UNITS - 1)) begin
          state_d     = GAP;
          last_dash_d = 1'b1;
        end
      end
      GAP: begin
        if (mode_b && last_dash_q && dot_p) dot_mem_d = 1'b1;
        if (mode_b && !last_dash_q && dash_p) dash_mem_d = 1'b1;
        if (unit_tick) begin
          // Alternation takes priority over repeating the same element.
          if (last_dash_q ? dot_req : dash_req) begin
            go_elem = 1'b1;
            go_dash = ~last_dash_q;
          end else if (last_dash_q ? dash_req : dot_req) begin
            go_elem = 1'b1;
            go_dash = last_dash_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_elem) begin
      state_d    = go_dash ? DASH : DOT;
      acc_d      = '0;
      el_cnt_d   = '0;
      units_d    = '0;
      dot_mem_d  = 1'b0;
      dash_mem_d = 1'b0;
    end

    if (!enable) begin
      state_d    = IDLE;
      dot_mem_d  = 1'b0;
      dash_mem_d = 1'b0;
    end

    key_d = (state_d == DOT) || (state_d == DASH);
  end

  // Sidetone follows the next key state so it falls on the same edge as the
  // key; it only counts once the key is actually down, giving a full first
  // half-period.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    if (!key_d) begin
      tone_cnt_d = '0;
      tone_d     = 1'b0;
    end else if (cwkey_q) begin
      if (tone_cnt_q == TW'(HALF_PER - 1)) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge IF_clk or negedge extreset) begin
    if (!extreset) begin
      state_q     <= IDLE;
      last_dash_q <= 1'b0;
      dot_mem_q   <= 1'b0;
      dash_mem_q  <= 1'b0;
      acc_q       <= '0;
      units_q     <= '0;
      el_cnt_q    <= '0;
      cwkey_q     <= 1'b0;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dash_q <= last_dash_d;
      dot_mem_q   <= dot_mem_d;
      dash_mem_q  <= dash_mem_d;
      acc_q       <= acc_d;
      units_q     <= units_d;
      el_cnt_q    <= el_cnt_d;
      cwkey_q     <= key_d;
      tone_cnt_q  <= tone_cnt_d;
      tone_q      <= tone_d;
    end
  end

  assign cwkey_o  = cwkey_q;
  assign sidetone = tone_q;
  assign busy     = (state_q != IDLE);

endmodule
